snake_game_sequencer: RTL and testbench
=======================================

Name: snake_game_sequencer

Overview:
Game-level controller that sequences the snake movement datapath. It accepts decoded keyboard make codes (scancode plus one-cycle strobe from the PS/2 receiver) and a pause switch, and runs a four-state game FSM (IDLE/RUN/PAUSE/OVER). It generates the movement tick, arbitrates direction changes (last valid key wins, no 180° reversal), advances the head coordinate and detects wall collision. It drives the head position, a one-cycle move pulse for the body-shift logic, the blackout flag for the VGA controller and a move counter for the 7-segment display.

Parameters:
TICK_DIV, 5000000, clk cycles per movement step (20 steps/s at 100 MHz); must be ≥ 2
STEP, 10, pixels added/subtracted per move
X_MAX, 630, largest legal head x
Y_MAX, 470, largest legal head y
X_START, 320, head x after reset/restart
Y_START, 240, head y after reset/restart

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
strobe  in  1  one-cycle pulse; scancode valid this cycle
scancode  in  8  PS/2 make code
pause_sw  in  1  level; high requests pause
head_x  out  10  current head x
head_y  out  10  current head y
move_pulse  out  1  high for exactly one cycle, the same cycle head_x/head_y first show the new value
blackout  out  1  high while in OVER
state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
move_count  out  8  moves since start, saturates at 255

Behaviour:
- Reset (rst=1 at a clk edge; wins over everything, including mid-move): state=IDLE, head=(X_START,Y_START), dir=pending=RIGHT, tick counter=0, move_pulse=0, blackout=0, move_count=0.
- Keys act only on the cycle strobe=1. Codes: 0x1D UP, 0x1B DOWN, 0x1C LEFT, 0x23 RIGHT, 0x29 SPACE. All other codes, including 0xF0, are ignored.
- Direction arbitration (IDLE and RUN only): a direction key sets pending, except a key opposite to the committed dir, which is dropped. Several keys within one tick: the last accepted key wins. Up then Left while moving right leaves pending=UP.
- IDLE: head frozen, counter held at 0. SPACE -> RUN, with counter=0.
- RUN: counter increments each cycle. At counter==TICK_DIV-1, counter returns to 0 and a move is evaluated:
  - dir takes pending, as registered before this edge. A key strobe in the same cycle affects the next tick only.
  - Next head = head ± STEP on one axis: UP y-STEP, DOWN y+STEP, LEFT x-STEP, RIGHT x+STEP.
  - Compute with 11-bit signed or extended arithmetic. Collision = result < 0, x > X_MAX, or y > Y_MAX.
  - No collision: head updates, move_pulse=1 for one cycle, move_count += 1 (saturating at 255).
  - Collision: head unchanged, no move_pulse, state -> OVER, blackout=1 on the next cycle.
- RUN with pause_sw=1: -> PAUSE. Pause has priority over a coincident tick: no move, and the counter holds its value.
- SPACE in RUN is ignored.
- PAUSE: counter, head, dir and pending frozen; all keys ignored. pause_sw=0 -> RUN, and counting resumes from the held value.
- OVER: blackout=1, head frozen, direction keys ignored. SPACE -> IDLE with the full reset values, except that it is a state transition and not a reset (takes one cycle).
- Latency: key to pending takes 1 cycle. Tick to head/move_pulse takes 1 cycle (registered outputs). All outputs are registered.

Test Plan:
Note: all scenarios use TICK_DIV=4 and default other parameters.
1. Reset, then SPACE -> state=01. First move_pulse occurs 4 cycles later with head=(330,240) and move_count=1. Pulses then repeat every 4 cycles.
2. RUN moving RIGHT: strobe 0x1C (LEFT) -> ignored, next head x=+10. Strobe 0x1D then 0x1C within one tick -> next move UP: y 240->230, x unchanged.
3. Drive head to x=630 moving RIGHT -> on the next tick there is no move_pulse, head stays at 630, state=11 and blackout=1. SPACE -> state=00, head=(320,240), move_count=0, blackout=0.
4. Moving UP from y=0 -> OVER (no underflow wrap to 1014). Same check for x=0 moving LEFT.
5. In RUN, raise pause_sw in the tick cycle -> state=10, no move_pulse, counter held. A key strobe during PAUSE changes nothing. Lower pause_sw -> next move arrives after the remaining counts only.
6. Assert rst mid-RUN in the cycle a tick fires -> no move_pulse, all outputs at reset values. Run 300 moves in a bounded arena -> move_count holds at 255.

Source files
------------

// File: rtl/snake_game_sequencer.sv
// Game-level sequencer for the snake datapath: key arbitration, movement tick,
// head stepping with wall collision, and the IDLE/RUN/PAUSE/OVER game FSM.
module snake_game_sequencer #(
  parameter int TICK_DIV = 5000000,
  parameter int STEP     = 10,
  parameter int X_MAX    = 630,
  parameter int Y_MAX    = 470,
  parameter int X_START  = 320,
  parameter int Y_START  = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe,
  input  logic [7:0] scancode,
  input  logic       pause_sw,
  output logic [9:0] head_x,
  output logic [9:0] head_y,
  output logic       move_pulse,
  output logic       blackout,
  output logic [1:0] state,
  output logic [7:0] move_count
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, OVER = 2'b11} state_t;
  typedef enum logic [1:0] {UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11} dir_t;

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0]      CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic signed [11:0] STEP_S   = 12'(STEP);
  localparam logic signed [11:0] XMAX_S   = 12'(X_MAX);
  localparam logic signed [11:0] YMAX_S   = 12'(Y_MAX);

  state_t            st;
  dir_t              dir, pending, key_dir, commit_dir;
  logic [CW-1:0]     cnt;
  logic              key_vld, key_space, accept_dir, tick, collide;
  logic signed [11:0] nx, ny;

  assign state = st;

  always_comb begin
    key_vld   = 1'b0;
    key_dir   = RIGHT;
    key_space = 1'b0;
    if (strobe) begin
      case (scancode)
        8'h1D:   begin key_vld = 1'b1; key_dir = UP;    end
        8'h1B:   begin key_vld = 1'b1; key_dir = DOWN;  end
        8'h1C:   begin key_vld = 1'b1; key_dir = LEFT;  end
        8'h23:   begin key_vld = 1'b1; key_dir = RIGHT; end
        8'h29:   key_space = 1'b1;
        default: ;
      endcase
    end
    tick = (st == RUN) && !pause_sw && (cnt == CNT_LAST);
    // Reversal is judged against the direction in force after this edge, so a
    // key arriving on a tick cannot queue a 180-degree turn for the next tick.
    commit_dir = tick ? pending : dir;
    accept_dir = key_vld && (key_dir != dir_t'(commit_dir ^ 2'b01));

    nx = $signed({2'b00, head_x});
    ny = $signed({2'b00, head_y});
    case (pending)
      UP:    ny = ny - STEP_S;
      DOWN:  ny = ny + STEP_S;
      LEFT:  nx = nx - STEP_S;
      RIGHT: nx = nx + STEP_S;
      default: ;
    endcase
    collide = nx[11] || ny[11] || (nx > XMAX_S) || (ny > YMAX_S);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      head_x     <= 10'(X_START);
      head_y     <= 10'(Y_START);
      dir        <= RIGHT;
      pending    <= RIGHT;
      cnt        <= '0;
      move_pulse <= 1'b0;
      blackout   <= 1'b0;
      move_count <= '0;
    end else begin
      move_pulse <= 1'b0;
      unique case (st)
        IDLE: begin
          cnt <= '0;
          if (accept_dir) pending <= key_dir;
          if (key_space) st <= RUN;
        end
        RUN: begin
          if (accept_dir) pending <= key_dir;
          if (pause_sw) begin
            st <= PAUSE;
          end else if (tick) begin
            cnt <= '0;
            dir <= pending;
            if (collide) begin
              st       <= OVER;
              blackout <= 1'b1;
            end else begin
              head_x     <= nx[9:0];
              head_y     <= ny[9:0];
              move_pulse <= 1'b1;
              if (move_count != 8'hFF) move_count <= move_count + 8'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PAUSE: begin
          if (!pause_sw) st <= RUN;
        end
        OVER: begin
          blackout <= 1'b1;
          if (key_space) begin
            st         <= IDLE;
            head_x     <= 10'(X_START);
            head_y     <= 10'(Y_START);
            dir        <= RIGHT;
            pending    <= RIGHT;
            cnt        <= '0;
            blackout   <= 1'b0;
            move_count <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Directed bench for snake_game_sequencer (TICK_DIV=4) with a behavioural
// game model checked every cycle plus literal spot checks.
module tb_snake_game_sequencer;

  localparam int TD = 4;
  localparam int ST = 10;
  localparam int XM = 630;
  localparam int YM = 470;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       strobe = 1'b0;
  logic [7:0] scancode = 8'h00;
  logic       pause_sw = 1'b0;
  logic [9:0] head_x, head_y;
  logic       move_pulse, blackout;
  logic [1:0] state;
  logic [7:0] move_count;

  snake_game_sequencer #(
    .TICK_DIV(TD), .STEP(ST), .X_MAX(XM), .Y_MAX(YM), .X_START(320), .Y_START(240)
  ) dut (
    .clk(clk), .rst(rst), .strobe(strobe), .scancode(scancode), .pause_sw(pause_sw),
    .head_x(head_x), .head_y(head_y), .move_pulse(move_pulse), .blackout(blackout),
    .state(state), .move_count(move_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: directions 0 up, 1 down, 2 left, 3 right; game phase 0..3.
  int m_phase, m_x, m_y, m_dir, m_pend, m_cnt, m_moves, m_pulse, m_black;
  int dx[4] = '{0, 0, -1, 1};
  int dy[4] = '{-1, 1, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit opposite(input int a, input int b);
    return (a == 0 && b == 1) || (a == 1 && b == 0) || (a == 2 && b == 3) || (a == 3 && b == 2);
  endfunction

  task automatic model_restart();
    m_phase = 0; m_x = 320; m_y = 240; m_dir = 3; m_pend = 3;
    m_cnt = 0; m_moves = 0; m_black = 0;
  endtask

  task automatic model_step();
    int kd, nx, ny, old_pend, eff;
    bit space, tick;
    m_pulse = 0;
    if (rst) begin
      model_restart();
      return;
    end
    kd = -1;
    space = 1'b0;
    if (strobe) begin
      if (scancode == 8'h1D) kd = 0;
      else if (scancode == 8'h1B) kd = 1;
      else if (scancode == 8'h1C) kd = 2;
      else if (scancode == 8'h23) kd = 3;
      else if (scancode == 8'h29) space = 1'b1;
    end
    if (m_phase == 0) begin
      if (kd >= 0 && !opposite(kd, m_dir)) m_pend = kd;
      if (space) m_phase = 1;
    end else if (m_phase == 1) begin
      tick = !pause_sw && (m_cnt == TD - 1);
      old_pend = m_pend;
      eff = tick ? m_pend : m_dir;
      if (kd >= 0 && !opposite(kd, eff)) m_pend = kd;
      if (pause_sw) m_phase = 2;
      else begin
        m_cnt = (m_cnt + 1) % TD;
        if (tick) begin
          m_dir = old_pend;
          nx = m_x + dx[old_pend] * ST;
          ny = m_y + dy[old_pend] * ST;
          if (nx < 0 || ny < 0 || nx > XM || ny > YM) begin
            m_phase = 3;
            m_black = 1;
          end else begin
            m_x = nx; m_y = ny; m_pulse = 1;
            if (m_moves < 255) m_moves++;
          end
        end
      end
    end else if (m_phase == 2) begin
      if (!pause_sw) m_phase = 1;
    end else begin
      if (space) model_restart();
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("head_x", 32'(head_x), 32'(m_x));
      chk("head_y", 32'(head_y), 32'(m_y));
      chk("move_pulse", 32'(move_pulse), 32'(m_pulse));
      chk("blackout", 32'(blackout), 32'(m_black));
      chk("state", 32'(state), 32'(m_phase));
      chk("move_count", 32'(move_count), 32'(m_moves));
    end
  end

  task automatic cyc(input logic r, input logic s, input logic [7:0] c, input logic p);
    rst = r; strobe = s; scancode = c; pause_sw = p;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic key(input logic [7:0] c);
    cyc(1'b0, 1'b1, c, 1'b0);
  endtask

  initial begin
    logic [7:0] sq [4];
    sq[0] = 8'h23; sq[1] = 8'h1B; sq[2] = 8'h1C; sq[3] = 8'h1D;

    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk_en = 1'b1;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_x", 32'(head_x), 32'd320);
    chk("reset_count", 32'(move_count), 32'd0);

    // Start and first moves
    key(8'h29);
    chk("start_state", 32'(state), 32'd1);
    idle(4);
    chk("first_pulse", 32'(move_pulse), 32'd1);
    chk("first_x", 32'(head_x), 32'd330);
    chk("first_count", 32'(move_count), 32'd1);
    idle(4);
    chk("second_x", 32'(head_x), 32'd340);

    // Reverse key dropped; up-then-left leaves up
    key(8'h1C); idle(3);
    chk("rev_drop_x", 32'(head_x), 32'd350);
    key(8'h1D); key(8'h1C); idle(2);
    chk("up_y", 32'(head_y), 32'd230);
    chk("up_x", 32'(head_x), 32'd350);

    // Right wall
    key(8'h23); idle(3);
    idle(27 * 4);
    chk("wall_x", 32'(head_x), 32'd630);
    idle(4);
    chk("wall_pulse", 32'(move_pulse), 32'd0);
    chk("wall_state", 32'(state), 32'd3);
    chk("wall_black", 32'(blackout), 32'd1);
    chk("wall_hold_x", 32'(head_x), 32'd630);
    key(8'h29);
    chk("restart_state", 32'(state), 32'd0);
    chk("restart_x", 32'(head_x), 32'd320);
    chk("restart_count", 32'(move_count), 32'd0);
    chk("restart_black", 32'(blackout), 32'd0);

    // Top wall, then left wall
    key(8'h29);
    key(8'h1D); idle(3);
    idle(23 * 4);
    chk("top_y", 32'(head_y), 32'd0);
    idle(4);
    chk("top_state", 32'(state), 32'd3);
    chk("top_hold_y", 32'(head_y), 32'd0);
    key(8'h29);
    key(8'h1D);
    key(8'h29);
    idle(4);
    key(8'h1C); idle(3);
    chk("left_x", 32'(head_x), 32'd310);
    idle(31 * 4);
    chk("left_edge_x", 32'(head_x), 32'd0);
    idle(4);
    chk("left_state", 32'(state), 32'd3);
    chk("left_hold_x", 32'(head_x), 32'd0);

    // Pause on the tick cycle
    key(8'h29);
    key(8'h29);
    idle(4);
    idle(3);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("pause_state", 32'(state), 32'd2);
    chk("pause_pulse", 32'(move_pulse), 32'd0);
    chk("pause_x", 32'(head_x), 32'd330);
    cyc(1'b0, 1'b1, 8'h1D, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    idle(1);
    chk("resume_state", 32'(state), 32'd1);
    chk("resume_nopulse", 32'(move_pulse), 32'd0);
    idle(1);
    chk("resume_pulse", 32'(move_pulse), 32'd1);
    chk("resume_x", 32'(head_x), 32'd340);
    chk("resume_y", 32'(head_y), 32'd240);

    // Reset on a tick cycle
    idle(3);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_tick_pulse", 32'(move_pulse), 32'd0);
    chk("rst_tick_state", 32'(state), 32'd0);
    chk("rst_tick_x", 32'(head_x), 32'd320);
    chk("rst_tick_count", 32'(move_count), 32'd0);

    // Saturation: circle a small square for 300 moves
    key(8'h29);
    for (int i = 0; i < 300; i++) begin
      key(sq[i % 4]);
      idle(3);
    end
    chk("sat_count", 32'(move_count), 32'd255);
    chk("sat_x", 32'(head_x), 32'd320);
    idle(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
